// File: rtl/branch_resolve_unit.sv
// Purpose: resolves execute-stage branches/jumps against static not-taken prediction, issues redirect + flush, counts branches.
// Latency: one cycle from accept edge to pc_src_o/branch_target_o/flush_o; flush_o lasts FLUSH_CYCLES unstalled cycles.
// Backpressure: stall_i freezes acceptance, the flush countdown and the counters; outputs hold except the one-cycle pc_src_o pulse.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             valid_i,
  input  logic [2:0]       branch_type_i,
  input  logic             jalr_i,
  input  logic             zero_flag_i,
  input  logic             lt_flag_i,
  input  logic             ltu_flag_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  rs1_i,
  output logic             pc_src_o,
  output logic [XLEN-1:0]  branch_target_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  localparam logic [2:0] BT_NONE = 3'd0;
  localparam logic [2:0] BT_BEQ  = 3'd1;
  localparam logic [2:0] BT_BNE  = 3'd2;
  localparam logic [2:0] BT_BLT  = 3'd3;
  localparam logic [2:0] BT_BGE  = 3'd4;
  localparam logic [2:0] BT_BLTU = 3'd5;
  localparam logic [2:0] BT_BGEU = 3'd6;
  localparam logic [2:0] BT_JUMP = 3'd7;

  // Flush counter holds remaining extra flush cycles after the redirect cycle.
  localparam logic [3:0]      FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0] JALR_MASK  = ~XLEN'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic             pc_src_q, pc_src_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic             accept;
  logic             taken;
  logic [XLEN-1:0]  target_calc;

  // Decode branch condition and compute the redirect address for the current instruction.
  always_comb begin
    taken = 1'b0;
    unique case (branch_type_i)
      BT_BEQ:  taken = zero_flag_i;
      BT_BNE:  taken = !zero_flag_i;
      BT_BLT:  taken = lt_flag_i;
      BT_BGE:  taken = !lt_flag_i;
      BT_BLTU: taken = ltu_flag_i;
      BT_BGEU: taken = !ltu_flag_i;
      BT_JUMP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    if (branch_type_i == BT_JUMP && jalr_i) begin
      target_calc = (rs1_i + imm_i) & JALR_MASK;
    end else begin
      target_calc = pc_i + imm_i;
    end
    // Wrong-path instructions arriving during a flush are never accepted.
    accept = (state_q == IDLE) && valid_i && !stall_i && (branch_type_i != BT_NONE);
  end

  // Next-state logic for the resolve FSM, redirect pulse and saturating counters.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    pc_src_d     = 1'b0;
    target_d     = target_q;
    flush_d      = flush_q;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (branch_cnt_q != CNT_MAX) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
          end
          if (taken) begin
            if (taken_cnt_q != CNT_MAX) begin
              taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
            pc_src_d = 1'b1;
            target_d = target_calc;
            flush_d  = 1'b1;
            fcnt_d   = FLUSH_LOAD;
            state_d  = FLUSH;
          end
        end
      end
      FLUSH: begin
        flush_d = 1'b1;
        if (!stall_i) begin
          if (fcnt_q == 4'd0) begin
            flush_d = 1'b0;
            state_d = IDLE;
          end else begin
            fcnt_d = fcnt_q - 4'd1;
          end
        end
      end
      default: begin
        flush_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // All state and outputs registered; reset clears them asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fcnt_q       <= 4'd0;
      pc_src_q     <= 1'b0;
      target_q     <= '0;
      flush_q      <= 1'b0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      pc_src_q     <= pc_src_d;
      target_q     <= target_d;
      flush_q      <= flush_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign pc_src_o        = pc_src_q;
  assign branch_target_o = target_q;
  assign flush_o         = flush_q;
  assign branch_cnt_o    = branch_cnt_q;
  assign taken_cnt_o     = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic against a cycle-level reference model.
// Two instances share stimulus: default CNT_W=16 and CNT_W=4 for counter saturation.
// All checks sample #1 after the rising edge.
module tb_branch_resolve_unit;
  localparam int FC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall_i, valid_i, jalr_i;
  logic [2:0]  bt;
  logic [31:0] pc, imm, rs1, rs2;
  logic        zero, lt, ltu;
  logic        pc_src, flush, pc_src4, flush4;
  logic [31:0] tgt, tgt4;
  logic [15:0] bcnt, tcnt;
  logic [3:0]  bcnt4, tcnt4;

  // Flags come from real operand values so the model can reason on rs1/rs2 directly.
  assign zero = (rs1 == rs2);
  assign lt   = ($signed(rs1) < $signed(rs2));
  assign ltu  = (rs1 < rs2);

  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .valid_i(valid_i), .branch_type_i(bt),
    .jalr_i(jalr_i), .zero_flag_i(zero), .lt_flag_i(lt), .ltu_flag_i(ltu),
    .pc_i(pc), .imm_i(imm), .rs1_i(rs1), .pc_src_o(pc_src), .branch_target_o(tgt),
    .flush_o(flush), .branch_cnt_o(bcnt), .taken_cnt_o(tcnt));

  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .valid_i(valid_i), .branch_type_i(bt),
    .jalr_i(jalr_i), .zero_flag_i(zero), .lt_flag_i(lt), .ltu_flag_i(ltu),
    .pc_i(pc), .imm_i(imm), .rs1_i(rs1), .pc_src_o(pc_src4), .branch_target_o(tgt4),
    .flush_o(flush4), .branch_cnt_o(bcnt4), .taken_cnt_o(tcnt4));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: remaining flush cycles, raw event counts, last redirect.
  int          m_flush_left;
  int          m_b, m_t;
  bit          m_pc_src;
  logic [31:0] m_tgt;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit m_taken();
    case (bt)
      3'd1: return rs1 == rs2;
      3'd2: return rs1 != rs2;
      3'd3: return $signed(rs1) < $signed(rs2);
      3'd4: return $signed(rs1) >= $signed(rs2);
      3'd5: return rs1 < rs2;
      3'd6: return rs1 >= rs2;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flush_left = 0; m_b = 0; m_t = 0; m_pc_src = 0; m_tgt = 32'h0;
  endtask

  // Evaluate what the coming rising edge does, from the inputs currently applied.
  task automatic model_tick();
    bit acc;
    acc = (m_flush_left == 0) && valid_i && !stall_i && (bt != 3'd0);
    m_pc_src = 0;
    if (acc) begin
      m_b++;
      if (m_taken()) begin
        m_t++;
        m_pc_src = 1;
        m_tgt = (bt == 3'd7 && jalr_i) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        m_flush_left = FC;
      end
    end else if (m_flush_left > 0 && !stall_i) begin
      m_flush_left--;
    end
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [2:0] t, input bit j, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p, input logic [31:0] i, input bit s);
    valid_i = v; bt = t; jalr_i = j; rs1 = a; rs2 = b; pc = p; imm = i; stall_i = s;
  endtask

  task automatic idle();
    drive(0, 3'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    #2;
    n_cmp++; if (pc_src !== 1'b0) begin n_bad++; $display("FAIL reset_pc_src got %b want 0", pc_src); end
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush got %b want 0", flush); end
    n_cmp++; if (tgt !== 32'h0) begin n_bad++; $display("FAIL reset_target got %h want 0", tgt); end
    n_cmp++; if (bcnt !== 16'h0 || tcnt !== 16'h0) begin n_bad++; $display("FAIL reset_counters got %h/%h want 0/0", bcnt, tcnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_beq_taken();
    apply_reset();
    drive(1, 3'd1, 0, 32'd5, 32'd5, 32'h100, 32'h20, 0);
    step();
    idle();
    n_cmp++; if (pc_src !== 1'b1) begin n_bad++; $display("FAIL beq_pc_src got %b want 1", pc_src); end
    n_cmp++; if (tgt !== 32'h120) begin n_bad++; $display("FAIL beq_target got %h want 120", tgt); end
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL beq_flush1 got %b want 1", flush); end
    n_cmp++; if (bcnt !== 16'd1 || tcnt !== 16'd1) begin n_bad++; $display("FAIL beq_counters got %0d/%0d want 1/1", bcnt, tcnt); end
    step();
    n_cmp++; if (pc_src !== 1'b0) begin n_bad++; $display("FAIL beq_pulse_width got %b want 0", pc_src); end
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL beq_flush2 got %b want 1", flush); end
    step();
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL beq_flush_end got %b want 0", flush); end
    n_cmp++; if (tgt !== 32'h120) begin n_bad++; $display("FAIL beq_target_hold got %h want 120", tgt); end
  endtask

  task automatic test_bne_not_taken();
    apply_reset();
    drive(1, 3'd2, 0, 32'd7, 32'd7, 32'h300, 32'h40, 0);
    step();
    idle();
    n_cmp++; if (pc_src !== 1'b0 || flush !== 1'b0) begin n_bad++; $display("FAIL bne_outputs got pc_src=%b flush=%b want 0/0", pc_src, flush); end
    n_cmp++; if (bcnt !== 16'd1 || tcnt !== 16'd0) begin n_bad++; $display("FAIL bne_counters got %0d/%0d want 1/0", bcnt, tcnt); end
    step();
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL bne_flush_late got %b want 0", flush); end
  endtask

  task automatic test_targets();
    apply_reset();
    drive(1, 3'd7, 1, 32'h1003, 32'h0, 32'h500, 32'h4, 0);
    step();
    idle();
    n_cmp++; if (pc_src !== 1'b1 || tgt !== 32'h1006) begin n_bad++; $display("FAIL jalr_target got %b/%h want 1/00001006", pc_src, tgt); end
    repeat (FC) step();
    drive(1, 3'd7, 0, 32'h1003, 32'h0, 32'hFFFF_FFF0, 32'h20, 0);
    step();
    idle();
    n_cmp++; if (pc_src !== 1'b1 || tgt !== 32'h10) begin n_bad++; $display("FAIL jal_wrap_target got %b/%h want 1/00000010", pc_src, tgt); end
    repeat (FC) step();
    n_cmp++; if (bcnt !== 16'd2 || tcnt !== 16'd2) begin n_bad++; $display("FAIL jump_counters got %0d/%0d want 2/2", bcnt, tcnt); end
  endtask

  task automatic test_flush_stall();
    int hi;
    apply_reset();
    hi = 0;
    drive(1, 3'd1, 0, 32'd9, 32'd9, 32'h200, 32'h8, 0);
    step();
    hi += flush;
    drive(1, 3'd1, 0, 32'd3, 32'd3, 32'h800, 32'h80, 0);
    step();
    hi += flush;
    n_cmp++; if (pc_src !== 1'b0 || tgt !== 32'h208) begin n_bad++; $display("FAIL flush_wrong_path got %b/%h want 0/00000208", pc_src, tgt); end
    drive(1, 3'd1, 0, 32'd3, 32'd3, 32'h800, 32'h80, 1);
    step();
    hi += flush;
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      hi += flush;
    end
    n_cmp++; if (hi !== 3) begin n_bad++; $display("FAIL flush_stall_len got %0d want 3", hi); end
    n_cmp++; if (bcnt !== 16'd1 || tcnt !== 16'd1) begin n_bad++; $display("FAIL flush_stall_counters got %0d/%0d want 1/1", bcnt, tcnt); end
  endtask

  task automatic test_reset_mid_flush();
    apply_reset();
    drive(1, 3'd1, 0, 32'd1, 32'd1, 32'h100, 32'h20, 0);
    step();
    idle();
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL midrst_pre got %b want 1", flush); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (flush !== 1'b0 || pc_src !== 1'b0) begin n_bad++; $display("FAIL midrst_async got flush=%b pc_src=%b want 0/0", flush, pc_src); end
    n_cmp++; if (tgt !== 32'h0 || bcnt !== 16'h0) begin n_bad++; $display("FAIL midrst_state got %h/%0d want 0/0", tgt, bcnt); end
    #3;
    rst_n = 1'b1;
    drive(1, 3'd5, 0, 32'd1, 32'd2, 32'h40, 32'h10, 0);
    step();
    idle();
    n_cmp++; if (pc_src !== 1'b1 || tgt !== 32'h50 || flush !== 1'b1) begin n_bad++; $display("FAIL midrst_bltu got %b/%h/%b want 1/00000050/1", pc_src, tgt, flush); end
    repeat (FC) step();
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      drive(1, 3'd7, 0, 32'h0, 32'h0, 32'h1000, 32'(k * 4), 0);
      step();
      idle();
      repeat (FC) step();
    end
    n_cmp++; if (bcnt4 !== 4'hF || tcnt4 !== 4'hF) begin n_bad++; $display("FAIL sat_cnt4 got %h/%h want F/F", bcnt4, tcnt4); end
    n_cmp++; if (bcnt !== 16'd17 || tcnt !== 16'd17) begin n_bad++; $display("FAIL sat_cnt16 got %0d/%0d want 17/17", bcnt, tcnt); end
  endtask

  task automatic test_random();
    logic [31:0] vals [4];
    apply_reset();
    vals[0] = 32'h0; vals[1] = 32'h1; vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h8000_0000;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            vals[$urandom_range(0, 3)], vals[$urandom_range(0, 3)], $urandom, $urandom,
            $urandom_range(0, 4) == 0);
      step();
      n_cmp++; if (pc_src !== m_pc_src) begin n_bad++; $display("FAIL rnd_pc_src cyc %0d got %b want %b", c, pc_src, m_pc_src); end
      n_cmp++; if (flush !== (m_flush_left > 0)) begin n_bad++; $display("FAIL rnd_flush cyc %0d got %b want %b", c, flush, m_flush_left > 0); end
      n_cmp++; if (tgt !== m_tgt) begin n_bad++; $display("FAIL rnd_target cyc %0d got %h want %h", c, tgt, m_tgt); end
      n_cmp++; if (bcnt !== 16'(sat(m_b, 65535)) || tcnt !== 16'(sat(m_t, 65535))) begin n_bad++; $display("FAIL rnd_cnt16 cyc %0d got %0d/%0d want %0d/%0d", c, bcnt, tcnt, m_b, m_t); end
      n_cmp++; if (bcnt4 !== 4'(sat(m_b, 15)) || tcnt4 !== 4'(sat(m_t, 15))) begin n_bad++; $display("FAIL rnd_cnt4 cyc %0d got %0d/%0d want %0d/%0d", c, bcnt4, tcnt4, sat(m_b, 15), sat(m_t, 15)); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_targets();
    test_flush_stall();
    test_reset_mid_flush();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage consumer of the ALU ZeroFlag and the companion less-than flags.
- Resolves conditional and unconditional branches against a static not-taken prediction.
- Issues a registered one-cycle PC redirect and a multi-cycle pipeline flush.
- Keeps saturating branch/taken performance counters for the UVM scoreboard.

Parameters:
- XLEN, 32, width of PC, immediate and target.
- FLUSH_CYCLES, 2, cycles flush_o stays high per taken branch; legal range 1..15.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  pipeline stall; freezes the unit.
- valid_i  input  1  execute-stage instruction valid.
- branch_type_i  input  3  0 NONE, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JUMP.
- jalr_i  input  1  with JUMP: 1 = JALR target, 0 = JAL target.
- zero_flag_i  input  1  ALU ZeroFlag (rs1 == rs2).
- lt_flag_i  input  1  signed rs1 < rs2.
- ltu_flag_i  input  1  unsigned rs1 < rs2.
- pc_i  input  XLEN  PC of the execute-stage instruction.
- imm_i  input  XLEN  sign-extended immediate.
- rs1_i  input  XLEN  rs1 value, used by JALR.
- pc_src_o  output  1  one-cycle redirect strobe.
- branch_target_o  output  XLEN  redirect address; valid while pc_src_o = 1.
- flush_o  output  1  squash IF/ID and ID/EX.
- branch_cnt_o  output  CNT_W  resolved branch/jump count.
- taken_cnt_o  output  CNT_W  taken count.

Behaviour:
- Reset, asynchronous: pc_src_o=0, branch_target_o=0, flush_o=0, both counters 0, state IDLE, flush counter 0.
- Accept condition: state IDLE and valid_i=1 and stall_i=0 and branch_type_i != 0.
- Taken condition:
  - BEQ: zero_flag_i.
  - BNE: !zero_flag_i.
  - BLT: lt_flag_i.
  - BGE: !lt_flag_i.
  - BLTU: ltu_flag_i.
  - BGEU: !ltu_flag_i.
  - JUMP: always taken.
- Target arithmetic, modulo 2^XLEN:
  - JALR: (rs1_i + imm_i) with bit0 cleared.
  - All others: pc_i + imm_i.
- Latency: all outputs are registered. The redirect appears on the cycle after the accept edge.
- State IDLE:
  - Accepted and taken: next cycle pc_src_o=1, branch_target_o=target, flush_o=1; load flush counter with FLUSH_CYCLES-1; go to FLUSH.
  - Accepted and not taken: outputs stay 0; only branch_cnt_o increments.
- pc_src_o is a single-cycle pulse; it is never extended by stall_i. branch_target_o holds its value until the next taken branch.
- State FLUSH:
  - flush_o stays 1.
  - If stall_i=0: when counter=0, deassert flush_o and return to IDLE; otherwise decrement the counter.
  - If stall_i=1: counter frozen and flush_o held at 1.
  - valid_i is wrong-path here: it is ignored, not counted and cannot redirect.
- flush_o is therefore high for exactly FLUSH_CYCLES unstalled cycles starting with the redirect cycle.
- Counters:
  - branch_cnt_o increments on every accept.
  - taken_cnt_o increments on every taken accept.
  - Both saturate at all-ones with no wrap.
- stall_i=1 in IDLE: no accept, no counter change, outputs hold (pc_src_o remains 0).
- Reset asserted mid-FLUSH: all outputs drop to 0 immediately (asynchronous); first accept after release behaves as from IDLE.
- A branch presented on the last flush cycle is dropped; the upstream flush guarantees it is wrong-path.

Test Plan:
- BEQ, zero_flag_i=1, pc_i=0x100, imm_i=0x20 -> next cycle pc_src_o=1 for one cycle, branch_target_o=0x120, flush_o high 2 cycles, branch_cnt_o=1, taken_cnt_o=1.
- BNE, zero_flag_i=1 -> pc_src_o and flush_o stay 0; branch_cnt_o=1, taken_cnt_o=0.
- JALR, rs1_i=0x1003, imm_i=0x4 -> branch_target_o=0x1006; JAL with pc_i=0xFFFFFFF0, imm_i=0x20 -> branch_target_o=0x10 (wrap).
- Taken branch, then valid_i=1 BEQ taken during flush and stall_i=1 on the 2nd flush cycle -> flush_o high 3 cycles total, second branch ignored, taken_cnt_o=1.
- Reset asserted on the first flush cycle -> flush_o and pc_src_o drop to 0 asynchronously; a BLTU with ltu_flag_i=1 after release redirects normally.
- CNT_W=4, 17 taken JUMPs -> both counters saturate at 0xF.
